gcn_trans_ctrl: RTL and testbench

GCN_TRANS_CTRL -- requirements
Module: gcn_trans_ctrl

---
 rtl/gcn_pkg.sv | 22 ++
 rtl/gcn_trans_ctrl_if.sv | 43 ++++
 rtl/gcn_wrap_counter.sv | 42 ++++
 rtl/gcn_trans_ctrl.sv | 131 +++++++++++++
 tb/tb_gcn_trans_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN transformation controller.
// State encoding, memory map bases and counter sizing helper.
package gcn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_W,
    S_LOAD_W,
    S_READ_F,
    S_MAC,
    S_DONE
  } gcn_state_e;

  localparam logic [12:0] WEIGHT_BASE  = 13'h000;
  localparam logic [12:0] FEATURE_BASE = 13'h200;

  // A counter over n values needs at least one bit even when n is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcn_trans_ctrl_if.sv
// Control bundle between the transformation controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface gcn_trans_ctrl_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int CW_W          = 2,
  parameter int CF_W          = 3
);

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     enable_read;
  logic                     load_weight;
  logic                     write_product;
  logic [CW_W-1:0]          weight_count;
  logic [CF_W-1:0]          feature_count;
  logic                     busy;
  logic                     done;

  modport master (
    input  start,
    output read_address,
    output enable_read,
    output load_weight,
    output write_product,
    output weight_count,
    output feature_count,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  read_address,
    input  enable_read,
    input  load_weight,
    input  write_product,
    input  weight_count,
    input  feature_count,
    input  busy,
    input  done
  );

endinterface

// File: rtl/gcn_wrap_counter.sv
// Up-counter that wraps from MAX back to zero.
// wrap_o flags the terminal value so the owner can chain counters.
module gcn_wrap_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap_o = (cnt_q == MaxVal);
  assign cnt_o  = cnt_q;

  // Clear wins over count; counting past the terminal value wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcn_trans_ctrl.sv
// Sequencer for one GCN transformation pass: per weight column, load
// the column, then stream every feature row through the MAC.
module gcn_trans_ctrl #(
  parameter int WEIGHT_COLS   = 3,
  parameter int FEATURE_ROWS  = 6,
  parameter int ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_BASE  = gcn_pkg::WEIGHT_BASE,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = gcn_pkg::FEATURE_BASE,
  parameter int COUNTER_WEIGHT_WIDTH  = gcn_pkg::cnt_w(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = gcn_pkg::cnt_w(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             enable_read,
  output logic                             load_weight,
  output logic                             write_product,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
  output logic                             busy,
  output logic                             done
);

  import gcn_pkg::*;

  gcn_state_e state_q;
  gcn_state_e state_d;

  logic w_en, w_clr, w_wrap;
  logic f_en, f_clr, f_wrap;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [ADDRESS_WIDTH-1:0] f_addr;

  gcn_wrap_counter #(
    .WIDTH (COUNTER_WEIGHT_WIDTH),
    .MAX   (WEIGHT_COLS - 1)
  ) u_wcnt (
    .clk    (clk),
    .rst    (reset),
    .en_i   (w_en),
    .clr_i  (w_clr),
    .cnt_o  (weight_count),
    .wrap_o (w_wrap)
  );

  gcn_wrap_counter #(
    .WIDTH (COUNTER_FEATURE_WIDTH),
    .MAX   (FEATURE_ROWS - 1)
  ) u_fcnt (
    .clk    (clk),
    .rst    (reset),
    .en_i   (f_en),
    .clr_i  (f_clr),
    .cnt_o  (feature_count),
    .wrap_o (f_wrap)
  );

  assign w_addr = WEIGHT_BASE + ADDRESS_WIDTH'(weight_count);
  assign f_addr = FEATURE_BASE + ADDRESS_WIDTH'(feature_count);

  // Next state and counter control; start is only looked at in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    w_en    = 1'b0;
    w_clr   = 1'b0;
    f_en    = 1'b0;
    f_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          w_clr   = 1'b1;
          f_clr   = 1'b1;
          state_d = S_READ_W;
        end
      end
      S_READ_W: state_d = S_LOAD_W;
      S_LOAD_W: state_d = S_READ_F;
      S_READ_F: state_d = S_MAC;
      S_MAC: begin
        f_en = 1'b1;
        if (!f_wrap) begin
          state_d = S_READ_F;
        end else if (!w_wrap) begin
          w_en    = 1'b1;
          state_d = S_READ_W;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; the address holds whenever no read is issued.
  always_comb begin
    enable_read   = (state_q == S_READ_W) || (state_q == S_READ_F);
    load_weight   = (state_q == S_LOAD_W);
    write_product = (state_q == S_MAC);
    done          = (state_q == S_DONE);
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    addr_d        = addr_q;
    unique case (1'b1)
      (state_q == S_READ_W): addr_d = w_addr;
      (state_q == S_READ_F): addr_d = f_addr;
      default:               addr_d = addr_q;
    endcase
  end

  assign read_address = addr_d;

  // State and held-address registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_gcn_trans_ctrl.sv
// Bench for gcn_trans_ctrl: default instance plus a 1x2 instance,
// checked cycle by cycle against a pass trace built from nested loops.
module tb_gcn_trans_ctrl;

  typedef struct packed {
    logic        en;
    logic        lw;
    logic        wp;
    logic        busy;
    logic        done;
    logic [31:0] addr;
    logic [31:0] wc;
    logic [31:0] fc;
  } obs_t;

  localparam logic [31:0] WB = 32'h000;
  localparam logic [31:0] FB = 32'h200;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  obs_t trA[$];
  obs_t trB[$];
  obs_t tmp_q[$];
  obs_t idleA;
  obs_t idleB;
  obs_t zero_o;

  gcn_trans_ctrl_if #(.ADDRESS_WIDTH(13), .CW_W(2), .CF_W(3)) busA ();
  gcn_trans_ctrl_if #(.ADDRESS_WIDTH(13), .CW_W(1), .CF_W(1)) busB ();

  gcn_trans_ctrl dutA (
    .clk           (clk),
    .reset         (reset),
    .start         (busA.start),
    .read_address  (busA.read_address),
    .enable_read   (busA.enable_read),
    .load_weight   (busA.load_weight),
    .write_product (busA.write_product),
    .weight_count  (busA.weight_count),
    .feature_count (busA.feature_count),
    .busy          (busA.busy),
    .done          (busA.done)
  );

  gcn_trans_ctrl #(
    .WEIGHT_COLS  (1),
    .FEATURE_ROWS (2)
  ) dutB (
    .clk           (clk),
    .reset         (reset),
    .start         (busB.start),
    .read_address  (busB.read_address),
    .enable_read   (busB.enable_read),
    .load_weight   (busB.load_weight),
    .write_product (busB.write_product),
    .weight_count  (busB.weight_count),
    .feature_count (busB.feature_count),
    .busy          (busB.busy),
    .done          (busB.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic en, input logic lw,
                              input logic wp, input logic bz,
                              input logic dn, input int a,
                              input int w, input int f);
    obs_t o;
    o.en   = en;
    o.lw   = lw;
    o.wp   = wp;
    o.busy = bz;
    o.done = dn;
    o.addr = 32'(a);
    o.wc   = 32'(w);
    o.fc   = 32'(f);
    return o;
  endfunction

  // Expected visible outputs of one pass, one entry per cycle, DONE last.
  task automatic build(input int nw, input int nf);
    tmp_q.delete();
    for (int w = 0; w < nw; w++) begin
      tmp_q.push_back(mk(1, 0, 0, 1, 0, int'(WB) + w, w, 0));
      tmp_q.push_back(mk(0, 1, 0, 1, 0, int'(WB) + w, w, 0));
      for (int f = 0; f < nf; f++) begin
        tmp_q.push_back(mk(1, 0, 0, 1, 0, int'(FB) + f, w, f));
        tmp_q.push_back(mk(0, 0, 1, 1, 0, int'(FB) + f, w, f));
      end
    end
    tmp_q.push_back(mk(0, 0, 0, 0, 1, int'(FB) + nf - 1, nw - 1, 0));
  endtask

  function automatic obs_t smp(input bit b);
    obs_t o;
    if (!b) begin
      o.en   = busA.enable_read;
      o.lw   = busA.load_weight;
      o.wp   = busA.write_product;
      o.busy = busA.busy;
      o.done = busA.done;
      o.addr = 32'(busA.read_address);
      o.wc   = 32'(busA.weight_count);
      o.fc   = 32'(busA.feature_count);
    end else begin
      o.en   = busB.enable_read;
      o.lw   = busB.load_weight;
      o.wp   = busB.write_product;
      o.busy = busB.busy;
      o.done = busB.done;
      o.addr = 32'(busB.read_address);
      o.wc   = 32'(busB.weight_count);
      o.fc   = 32'(busB.feature_count);
    end
    return o;
  endfunction

  task automatic check(input string tag, input obs_t g, input obs_t e);
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s got en%b lw%b wp%b bz%b dn%b a=%h w=%0d f=%0d exp en%b lw%b wp%b bz%b dn%b a=%h w=%0d f=%0d",
             tag, g.en, g.lw, g.wp, g.busy, g.done, g.addr, g.wc, g.fc,
             e.en, e.lw, e.wp, e.busy, e.done, e.addr, e.wc, e.fc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit b, input logic v);
    if (b) busB.start = v;
    else   busA.start = v;
  endtask

  // One pass: start held for 'hold' cycles, optional reset once
  // 'rst_at' cycles of the pass have been checked (-1 = none).
  task automatic run_pass(input bit b, input int hold, input int rst_at,
                          output int wp_cnt);
    obs_t tr[$];
    obs_t e;
    obs_t g;
    int   i;
    int   held;
    logic st;
    if (b) tr = trB;
    else   tr = trA;
    wp_cnt = 0;
    i      = 0;
    held   = 1;
    set_start(b, 1'b1);
    for (int k = 0; k < 300; k++) begin
      step();
      e = (i < tr.size()) ? tr[i] : tr[tr.size() - 1];
      g = smp(b);
      check($sformatf("dut%0d.cyc%0d", b, i), g, e);
      if (g.wp === 1'b1) wp_cnt++;
      i++;
      if (i == rst_at) begin
        reset = 1'b1;
        step();
        check($sformatf("dut%0d.rst", b), smp(b), zero_o);
        reset = 1'b0;
        set_start(b, 1'b0);
        idleA = zero_o;
        idleB = zero_o;
        return;
      end
      st = (held < hold);
      held++;
      set_start(b, st);
      if (i >= tr.size() && !st) begin
        step();
        e = tr[tr.size() - 1];
        e.done = 1'b0;
        check($sformatf("dut%0d.idle", b), smp(b), e);
        if (b) idleB = e;
        else   idleA = e;
        return;
      end
    end
    tests++;
    fails++;
    $error("FAIL dut%0d.timeout got no return to IDLE exp IDLE", b);
  endtask

  int wpc;
  int hold;
  int rst_at;
  int gap;

  initial begin
    tests  = 0;
    fails  = 0;
    zero_o = mk(0, 0, 0, 0, 0, 0, 0, 0);
    idleA  = zero_o;
    idleB  = zero_o;
    build(3, 6);
    trA = tmp_q;
    build(1, 2);
    trB = tmp_q;

    busA.start = 1'b0;
    busB.start = 1'b0;
    reset      = 1'b1;
    step();
    step();
    check("rstA", smp(0), zero_o);
    check("rstB", smp(1), zero_o);
    reset = 1'b0;
    step();
    check("idleA", smp(0), idleA);

    // Single-cycle start, full default pass.
    run_pass(0, 1, -1, wpc);
    tests++;
    assert (wpc == 18) else begin
      fails++;
      $error("FAIL wp_pulses got %0d exp 18", wpc);
    end

    // Start held well past DONE: no second pass.
    run_pass(0, 70, -1, wpc);

    // Reset during MAC at (1,3), then a clean pass.
    run_pass(0, 1, 24, wpc);
    run_pass(0, 1, -1, wpc);
    tests++;
    assert (wpc == 18) else begin
      fails++;
      $error("FAIL wp_after_rst got %0d exp 18", wpc);
    end

    // Reset and start together in IDLE.
    reset      = 1'b1;
    busA.start = 1'b1;
    step();
    idleA = zero_o;
    idleB = zero_o;
    check("rst_start", smp(0), zero_o);
    reset      = 1'b0;
    busA.start = 1'b0;
    step();
    check("rst_start2", smp(0), zero_o);

    // Small configuration.
    run_pass(1, 1, -1, wpc);
    tests++;
    assert (wpc == 2) else begin
      fails++;
      $error("FAIL wpB got %0d exp 2", wpc);
    end
    run_pass(1, 12, -1, wpc);

    // Random start lengths, idle gaps and reset injection.
    for (int n = 0; n < 12; n++) begin
      hold   = int'($urandom_range(1, 60));
      rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 45)) : -1;
      gap    = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) begin
        step();
        check("gapA", smp(0), idleA);
      end
      run_pass(n[0] & (n > 8), hold, rst_at, wpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
